// File: rtl/ctrl_pkg.sv
// ctrl_seq shared constants: state encodings, opcodes, IR field positions.
// Optional sticky illegal-opcode trap enabled by ILLEGAL_TRAP_EN.
package ctrl_pkg;

  localparam int IW_DEF   = 9;
  localparam int NREG_DEF = 8;
  localparam int CNT_DEF  = 16;

  typedef enum logic [4:0] {
    S_IDLE   = 5'b11111,
    S_FETCH  = 5'b10000,
    S_DECODE = 5'b00000,
    S_LOAD   = 5'b00001,
    S_MOV    = 5'b00010,
    S_ALU1   = 5'b00011,
    S_ALU2   = 5'b00100,
    S_ALU3   = 5'b00101
  } state_e;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_MOV  = 3'b001,
    OP_ADD  = 3'b010,
    OP_XOR  = 3'b011,
    OP_OR   = 3'b100,
    OP_AND  = 3'b101
  } op_e;

  function automatic int op_lsb(int iw);
    return iw - 3;
  endfunction

  function automatic int rx_lsb(int iw);
    return iw - 6;
  endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// ctrl_seq bus: instruction input, next-state loop and datapath strobes.
// master = sequencer side, slave = datapath / next-state side.
interface ctrl_seq_if #(
  parameter int IW    = 9,
  parameter int NREG  = 8,
  parameter int CNT_W = 16
);
  logic [IW-1:0]    din;
  logic [4:0]       next_state_i;
  logic [4:0]       state_o;
  logic [2:0]       code_o;
  logic             ir_in;
  logic             din_out;
  logic [NREG-1:0]  rx_in;
  logic [NREG-1:0]  rx_out;
  logic [NREG-1:0]  ry_out;
  logic             a_in;
  logic             g_in;
  logic             g_out;
  logic [2:0]       alu_op;
  logic             done;
  logic [CNT_W-1:0] instr_count;
  logic             illegal_op;

  modport master (
    input  din, next_state_i,
    output state_o, code_o, ir_in, din_out,
    output rx_in, rx_out, ry_out,
    output a_in, g_in, g_out, alu_op,
    output done, instr_count, illegal_op
  );

  modport slave (
    output din, next_state_i,
    input  state_o, code_o, ir_in, din_out,
    input  rx_in, rx_out, ry_out,
    input  a_in, g_in, g_out, alu_op,
    input  done, instr_count, illegal_op
  );
endinterface

// File: rtl/ctrl_seq_onehot_dec.sv
// 3-bit register index to NREG-wide one-hot select, gated by enable.
module onehot_dec #(
  parameter int NREG = 8
) (
  input  logic            en,
  input  logic [2:0]      idx,
  output logic [NREG-1:0] oh
);
  assign oh = en ? (NREG'(1) << idx) : '0;
endmodule

// File: rtl/ctrl_seq.sv
// Control sequencer: state register, IR, Moore strobe decode, retire count.
// Define ILLEGAL_TRAP_EN for the sticky illegal-opcode flag.
module ctrl_seq #(
  parameter int IW    = 9,
  parameter int NREG  = 8,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  ctrl_seq_if.master bus
);
  import ctrl_pkg::*;

  localparam int OPL = op_lsb(IW);
  localparam int RXL = rx_lsb(IW);

  logic [4:0]       state;
  logic [IW-1:0]    ir;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       code;
  logic [2:0]       rx;
  logic [2:0]       ry;

  assign code = ir[OPL +: 3];
  assign rx   = ir[RXL +: 3];
  assign ry   = ir[2:0];

  logic st_fetch, st_load, st_mov;
  logic st_alu1, st_alu2, st_alu3;

  assign st_fetch = state == S_FETCH;
  assign st_load  = state == S_LOAD;
  assign st_mov   = state == S_MOV;
  assign st_alu1  = state == S_ALU1;
  assign st_alu2  = state == S_ALU2;
  assign st_alu3  = state == S_ALU3;

  logic       ir_ld;
  logic       dout;
  logic       rxin_en;
  logic       rxout_en;
  logic       ryout_en;
  logic       a_ld;
  logic       g_ld;
  logic       g_drv;
  logic [2:0] op;
  logic       done;

  // No transition checks here: the next-state block owns sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= bus.next_state_i;
      if (ir_ld) ir <= bus.din;
      if (done) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    ir_ld    = 1'b0;
    dout     = 1'b0;
    rxin_en  = 1'b0;
    rxout_en = 1'b0;
    ryout_en = 1'b0;
    a_ld     = 1'b0;
    g_ld     = 1'b0;
    g_drv    = 1'b0;
    op       = 3'b000;
    done     = 1'b0;
    unique case (1'b1)
      st_fetch: ir_ld = 1'b1;
      st_load: begin
        dout    = 1'b1;
        rxin_en = 1'b1;
        done    = 1'b1;
      end
      st_mov: begin
        ryout_en = 1'b1;
        rxin_en  = 1'b1;
        done     = 1'b1;
      end
      st_alu1: begin
        rxout_en = 1'b1;
        a_ld     = 1'b1;
      end
      st_alu2: begin
        ryout_en = 1'b1;
        g_ld     = 1'b1;
        op       = code;
      end
      st_alu3: begin
        g_drv   = 1'b1;
        rxin_en = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  onehot_dec #(.NREG(NREG)) u_rxin (
    .en  (rxin_en),
    .idx (rx),
    .oh  (bus.rx_in)
  );

  onehot_dec #(.NREG(NREG)) u_rxout (
    .en  (rxout_en),
    .idx (rx),
    .oh  (bus.rx_out)
  );

  onehot_dec #(.NREG(NREG)) u_ryout (
    .en  (ryout_en),
    .idx (ry),
    .oh  (bus.ry_out)
  );

  assign bus.state_o     = state;
  assign bus.code_o      = code;
  assign bus.ir_in       = ir_ld;
  assign bus.din_out     = dout;
  assign bus.a_in        = a_ld;
  assign bus.g_in        = g_ld;
  assign bus.g_out       = g_drv;
  assign bus.alu_op      = op;
  assign bus.done        = done;
  assign bus.instr_count = cnt;

`ifdef ILLEGAL_TRAP_EN
  logic ill_q;

  // Opcodes 110/111 are unassigned; flag them once decoded.
  always_ff @(posedge clk) begin
    if (rst) begin
      ill_q <= 1'b0;
    end else if (state == S_DECODE && code[2:1] == 2'b11) begin
      ill_q <= 1'b1;
    end
  end

  assign bus.illegal_op = ill_q;
`else
  assign bus.illegal_op = 1'b0;
`endif

endmodule
